// File: rtl/data_mem_if.sv
// Bus between the EX/MEM side of the pipeline and the data-memory stage.
// The master drives the request fields and the slave returns load data and status.
interface data_mem_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [63:0] Address;
    logic [63:0] Write_Data;
    logic [63:0] Read_Data;
    logic        stall;
    logic        misaligned;

    modport master (
        output MemRead, MemWrite, funct3, Address, Write_Data,
        input  Read_Data, stall, misaligned
    );

    modport slave (
        input  MemRead, MemWrite, funct3, Address, Write_Data,
        output Read_Data, stall, misaligned
    );
endinterface

// File: rtl/data_mem_stage.sv
// RV64I data-memory stage: byte-lane loads and stores against an internal little-endian memory.
// An accepted access stalls the pipeline for LATENCY cycles, then presents the result for one DONE cycle.
module data_mem_stage #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic     clk,
    input  logic     reset,
    data_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          write_reg;
    logic [2:0]    funct3_reg;
    logic [AW+2:0] addr_reg;
    logic [63:0]   wdata_reg;
    logic [63:0]   read_data_reg;

    logic [63:0]   mem [DEPTH_WORDS];

    logic          req, aligned, do_access, stall, misaligned;
    logic          acc_write;
    logic [2:0]    acc_f3;
    logic [AW+2:0] acc_addr;
    logic [63:0]   acc_wdata;
    logic [AW-1:0] idx;
    logic [2:0]    lane;
    logic [63:0]   old_word, merged, wdata_sh, shifted, load_val;
    logic [7:0]    be;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^bus.Address[63:AW+3];

    assign req = bus.MemRead | bus.MemWrite;

    always_comb begin
        aligned = 1'b1;
        case (bus.funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = (bus.Address[0] == 1'b0);
            2'b10:   aligned = (bus.Address[1:0] == 2'b00);
            default: aligned = (bus.Address[2:0] == 3'b000);
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        do_access  = 1'b0;
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        misaligned = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        cnt_next = 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            do_access  = 1'b1;
                            state_next = DONE;
                        end else begin
                            state_next = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                stall    = 1'b1;
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    do_access  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Reset overrides everything so a pending store is dropped, not committed.
        if (reset) begin
            stall      = 1'b0;
            misaligned = 1'b0;
            do_access  = 1'b0;
        end
    end

    // With LATENCY==1 the access happens in the request cycle, straight from the bus.
    always_comb begin
        if (state_reg == IDLE) begin
            acc_write = bus.MemWrite;
            acc_f3    = bus.funct3;
            acc_addr  = bus.Address[AW+2:0];
            acc_wdata = bus.Write_Data;
        end else begin
            acc_write = write_reg;
            acc_f3    = funct3_reg;
            acc_addr  = addr_reg;
            acc_wdata = wdata_reg;
        end
    end

    assign idx      = acc_addr[AW+2:3];
    assign lane     = acc_addr[2:0];
    assign old_word = mem[idx];
    assign wdata_sh = acc_wdata << {lane, 3'b000};
    assign shifted  = old_word >> {lane, 3'b000};

    always_comb begin
        be = 8'h00;
        case (acc_f3[1:0])
            2'b00:   be = 8'h01 << lane;
            2'b01:   be = 8'h03 << lane;
            2'b10:   be = 8'h0F << lane;
            default: be = 8'hFF;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = be[gi] ? wdata_sh[gi*8 +: 8] : old_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        load_val = shifted;
        case (acc_f3)
            3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_val = {56'd0, shifted[7:0]};
            3'b101:  load_val = {48'd0, shifted[15:0]};
            3'b110:  load_val = {32'd0, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            read_data_reg <= 64'd0;
            write_reg     <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_reg      <= '0;
            wdata_reg     <= 64'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == IDLE && req && aligned) begin
                write_reg  <= bus.MemWrite;
                funct3_reg <= bus.funct3;
                addr_reg   <= bus.Address[AW+2:0];
                wdata_reg  <= bus.Write_Data;
            end
            if (misaligned) begin
                read_data_reg <= 64'd0;
            end else if (do_access) begin
                read_data_reg <= acc_write ? 64'd0 : load_val;
            end
        end
    end

    // Memory contents survive reset; do_access is already suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (do_access && acc_write) begin
            mem[idx] <= merged;
        end
    end

    assign bus.Read_Data  = read_data_reg;
    assign bus.stall      = stall;
    assign bus.misaligned = misaligned;
endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: a byte-array model predicts stall/misaligned/Read_Data every cycle.
// A second instance with LATENCY=1 is checked against literal timing.
module tb_data_mem_stage;
    localparam int LAT = 3;
    localparam int MEM_BYTES = 64 * 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_if b3();
    data_mem_if b1();

    data_mem_stage #(.DEPTH_WORDS(64), .LATENCY(LAT)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));
    data_mem_stage #(.DEPTH_WORDS(64), .LATENCY(1))   u_dut1 (.clk(clk), .reset(reset), .bus(b1));

    int tests = 0;
    int fails = 0;

    logic [7:0]  mm [MEM_BYTES];
    logic [63:0] exp_rd, rd_next;
    logic        exp_stall, exp_mis;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", nm, act, req_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",      64'(b3.stall),      64'(exp_stall));
            chk("misaligned", 64'(b3.misaligned), 64'(exp_mis));
            chk("Read_Data",  b3.Read_Data,       exp_rd);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        exp_rd = rd_next;
    endtask

    task automatic drive3(input bit w, input bit r, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd);
        b3.MemWrite = w; b3.MemRead = r; b3.funct3 = f3; b3.Address = a; b3.Write_Data = wd;
    endtask

    // Result of the access under the architectural rules, applied to the byte model.
    function automatic logic [63:0] model_access(input bit w, input logic [2:0] f3,
                                                 input logic [63:0] a, input logic [63:0] wd);
        int sz = 1 << f3[1:0];
        logic [63:0] v = 64'd0;
        for (int i = 0; i < sz; i++) begin
            if (w) mm[(a + 64'(i)) % MEM_BYTES] = wd[8*i +: 8];
            else   v[8*i +: 8] = mm[(a + 64'(i)) % MEM_BYTES];
        end
        if (w) return 64'd0;
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        return v;
    endfunction

    task automatic op(input bit w, input bit r, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, input bit has_lit, input logic [63:0] lit,
                      input string nm);
        int sz = 1 << f3[1:0];
        int nst = 0;
        if (!(w | r)) begin
            cyc();
            drive3(0, 0, f3, a, wd);
            exp_stall = 0; exp_mis = 0;
            @(negedge clk);
        end else if ((a % 64'(sz)) != 0) begin
            cyc();
            drive3(w, r, f3, a, wd);
            exp_stall = 0; exp_mis = 1; rd_next = 64'd0;
            @(negedge clk);
        end else begin
            for (int k = 0; k <= LAT; k++) begin
                cyc();
                if (k == 0) drive3(w, r, f3, a, wd);
                exp_stall = (k < LAT); exp_mis = 0;
                if (k == LAT - 1) rd_next = model_access(w, f3, a, wd);
                @(negedge clk);
                if (b3.stall) nst++;
                if (k == LAT && has_lit) chk(nm, b3.Read_Data, lit);
            end
            chk({nm, " stall cycles"}, 64'(nst), 64'(LAT));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
        rd_next = 64'd0; exp_rd = 64'd0; exp_stall = 0; exp_mis = 0;
        reset = 1'b1;
        drive3(0, 0, 3'd0, 64'd0, 64'd0);
        b1.MemWrite = 0; b1.MemRead = 0; b1.funct3 = 3'd0; b1.Address = 64'd0; b1.Write_Data = 64'd0;

        // Reset state, with an aligned request present while reset is high.
        cyc();
        chk_en = 1'b1;
        drive3(0, 1, 3'd3, 64'h0, 64'd0);
        @(negedge clk);
        cyc();
        reset = 1'b0;
        drive3(0, 0, 3'd0, 64'd0, 64'd0);
        @(negedge clk);

        // Reset in the 2nd stall cycle drops the store.
        op(1, 0, 3'd3, 64'h10, 64'd0, 0, 64'd0, "SD 0x10 zero");
        cyc();
        drive3(1, 0, 3'd3, 64'h10, 64'hDEADBEEF_CAFEF00D);
        exp_stall = 1; exp_mis = 0;
        @(negedge clk);
        cyc();
        reset = 1'b1;
        exp_stall = 0; exp_mis = 0; rd_next = 64'd0;
        @(negedge clk);
        cyc();
        reset = 1'b0;
        drive3(0, 0, 3'd0, 64'd0, 64'd0);
        @(negedge clk);
        chk("Read_Data after reset", b3.Read_Data, 64'd0);
        op(0, 1, 3'd3, 64'h10, 0, 1, 64'd0, "LD 0x10 after aborted SD");

        // Latency.
        op(1, 0, 3'd3, 64'h08, 64'h11223344_55667788, 1, 64'd0, "SD 0x08");
        op(0, 1, 3'd3, 64'h08, 0, 1, 64'h11223344_55667788, "LD 0x08");
        op(0, 0, 3'd0, 64'h0, 0, 0, 64'd0, "non-memory");

        // Byte and half stores, sign/zero extension.
        op(1, 0, 3'd3, 64'h20, 64'd0, 0, 64'd0, "SD 0x20");
        op(1, 0, 3'd0, 64'h23, 64'hAAAAAAAA_AAAAAA80, 0, 64'd0, "SB 0x23");
        op(0, 1, 3'd0, 64'h23, 0, 1, 64'hFFFFFFFF_FFFFFF80, "LB 0x23");
        op(0, 1, 3'd4, 64'h23, 0, 1, 64'h00000000_00000080, "LBU 0x23");
        op(0, 1, 3'd3, 64'h20, 0, 1, 64'h00000000_80000000, "LD 0x20");
        op(1, 0, 3'd1, 64'h26, 64'h55555555_5555BEEF, 0, 64'd0, "SH 0x26");
        op(0, 1, 3'd1, 64'h26, 0, 1, 64'hFFFFFFFF_FFFFBEEF, "LH 0x26");
        op(0, 1, 3'd5, 64'h26, 0, 1, 64'h00000000_0000BEEF, "LHU 0x26");

        // Word ops.
        op(1, 0, 3'd3, 64'h30, 64'd0, 0, 64'd0, "SD 0x30");
        op(1, 0, 3'd2, 64'h34, 64'h12345678_89ABCDEF, 0, 64'd0, "SW 0x34");
        op(0, 1, 3'd2, 64'h34, 0, 1, 64'hFFFFFFFF_89ABCDEF, "LW 0x34");
        op(0, 1, 3'd6, 64'h34, 0, 1, 64'h00000000_89ABCDEF, "LWU 0x34");
        op(0, 1, 3'd3, 64'h30, 0, 1, 64'h89ABCDEF_00000000, "LD 0x30");

        // Misaligned and wrap-around.
        op(0, 1, 3'd2, 64'h42, 0, 0, 64'd0, "LW 0x42 misaligned");
        op(1, 0, 3'd3, 64'h40, 64'h01234567_89ABCDEF, 0, 64'd0, "SD 0x40");
        op(1, 0, 3'd3, 64'h44, 64'hFFFFFFFF_FFFFFFFF, 0, 64'd0, "SD 0x44 misaligned");
        op(0, 1, 3'd1, 64'h43, 0, 0, 64'd0, "LH 0x43 misaligned");
        op(0, 1, 3'd3, 64'h40, 0, 1, 64'h01234567_89ABCDEF, "LD 0x40");
        op(1, 0, 3'd3, 64'h200, 64'h1234, 0, 64'd0, "SD 0x200");
        op(0, 1, 3'd3, 64'h0, 0, 1, 64'h1234, "LD 0x0 wrap");

        // Simultaneous read+write, then back-to-back load.
        op(1, 1, 3'd3, 64'h50, 64'h55, 1, 64'd0, "SD+RD 0x50");
        op(0, 1, 3'd3, 64'h50, 0, 1, 64'h55, "LD 0x50");
        op(0, 0, 3'd0, 64'h0, 0, 0, 64'd0, "non-memory tail");
        chk_en = 1'b0;

        // LATENCY=1 instance: one stall cycle per access.
        cyc();
        b1.MemWrite = 1; b1.MemRead = 0; b1.funct3 = 3'd3; b1.Address = 64'h08; b1.Write_Data = 64'h77;
        @(negedge clk);
        chk("L1 SD stall", 64'(b1.stall), 64'd1);
        cyc();
        @(negedge clk);
        chk("L1 SD done stall", 64'(b1.stall), 64'd0);
        chk("L1 SD Read_Data", b1.Read_Data, 64'd0);
        cyc();
        b1.MemWrite = 0; b1.MemRead = 1;
        @(negedge clk);
        chk("L1 LD stall", 64'(b1.stall), 64'd1);
        cyc();
        @(negedge clk);
        chk("L1 LD done stall", 64'(b1.stall), 64'd0);
        chk("L1 LD Read_Data", b1.Read_Data, 64'h77);
        cyc();
        b1.MemRead = 0;
        @(negedge clk);
        chk("L1 idle stall", 64'(b1.stall), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Data-memory access stage of the 64-bit RV64I pipeline, sitting between the EX/MEM register and the MEM/WB register. It performs loads (byte/half/word/double, signed and unsigned) and stores (byte/half/word/double) against an internal little-endian memory with a configurable multi-cycle access latency. While an access is in flight it raises `stall` so the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM. Its `Read_Data` output feeds the MEM/WB register's `Read_Data` input.

## Interface
- `DEPTH_WORDS`, 64: number of 64-bit doublewords in the memory; power of two, 2..4096.
- `LATENCY`, 2: stall cycles per accepted access; range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `MemRead` input 1: load request from EX/MEM.
- `MemWrite` input 1: store request from EX/MEM.
- `funct3` input 3: access type. 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
- `Address` input 64: byte address (ALU result from EX/MEM).
- `Write_Data` input 64: store data; low bytes are used for narrow stores.
- `Read_Data` output 64: registered load result, valid in the DONE cycle.
- `stall` output 1: combinational; high while the stage is occupied.
- `misaligned` output 1: combinational; one-cycle flag for a rejected misaligned access.

## Operation
- Request: `req = MemRead | MemWrite`. If both are high, the store takes priority and the read is ignored.
- Size is taken from `funct3[1:0]`: 1, 2, 4 or 8 bytes.
- Alignment: the access is aligned when `Address` modulo size is 0.
- Indexing:
  - Doubleword index is `Address[log2(DEPTH_WORDS)+2:3]`.
  - Byte lane is `Address[2:0]`.
  - Higher address bits are ignored, so accesses wrap modulo DEPTH_WORDS×8 bytes.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No `req`: `stall`=0, `misaligned`=0, `Read_Data` holds its value.
  - `req` with a misaligned address: `misaligned`=1, `stall`=0 for this cycle, memory unchanged, `Read_Data` set to 0 at the edge, stay in IDLE.
  - `req` aligned: `stall`=1. Latch the op, `funct3`, `Address` and `Write_Data`. Load the counter with LATENCY-1. Next state is DONE if LATENCY==1 (the access is performed at this edge), otherwise BUSY.
- BUSY:
  - `stall`=1; inputs are ignored and the latched copies are used.
  - The counter decrements each cycle.
  - On the cycle where the counter is 1: perform the access at the edge and go to DONE.
- Access:
  - Store: write only the addressed byte lanes of the doubleword; other bytes are unchanged.
  - Load: extract the addressed bytes. Sign-extend for funct3 000/001/010; zero-extend for 100/101/110; pass the full doubleword for 011. Register the result into `Read_Data`.
  - Store result: `Read_Data` is set to 0.
- DONE:
  - `stall`=0; `Read_Data` is valid and MEM/WB captures it at this edge.
  - Inputs still show the same held instruction and are ignored.
  - Next state is always IDLE.
- Reset (synchronous, including mid-operation):
  - State goes to IDLE and the counter is cleared.
  - Any pending store is dropped and not committed.
  - `Read_Data`=0; `stall` and `misaligned` are 0 from the reset cycle onward.
- Memory contents are not affected by reset and are zero at time zero.

## Timing
- A non-memory instruction takes 1 cycle in the stage with no stall.
- An aligned access stalls for exactly LATENCY cycles (request cycle plus LATENCY-1 BUSY cycles), followed by 1 DONE cycle: LATENCY+1 cycles total.
- A store is visible to a load accepted in any later IDLE cycle.
- Back-to-back memory instructions: the second one is presented in the IDLE cycle after DONE, so there is no bubble beyond that.
- A misaligned access occupies 1 cycle; `misaligned` is high for exactly that cycle.
- Both `stall` and `misaligned` are 0 whenever `reset`=1.

## Test plan
- Reset mid-BUSY: SD 0xDEADBEEF_CAFEF00D at 0x10 with LATENCY=3, reset asserted in the 2nd stall cycle, then LD 0x10 → returns 0 and `Read_Data`=0 after reset.
- Latency: LATENCY=3, LD 0x08 → `stall` high exactly 3 cycles, `Read_Data` valid in the 4th cycle; with LATENCY=1 → 1 stall cycle.
- Byte/half stores and sign extension:
  - SD 0x0 at 0x20, then SB 0x80 at 0x23.
  - LB 0x23 → 0xFFFFFFFF_FFFFFF80; LBU 0x23 → 0x80; LD 0x20 → 0x00000000_80000000.
  - SH 0xBEEF at 0x26, then LH 0x26 → 0xFFFFFFFF_FFFFBEEF; LHU 0x26 → 0xBEEF.
- Word ops:
  - SW 0x89ABCDEF at 0x34, then LW 0x34 → 0xFFFFFFFF_89ABCDEF; LWU 0x34 → 0x89ABCDEF.
  - LD 0x30 → 0x89ABCDEF_00000000 (other bytes untouched).
- Misaligned and wrap-around:
  - LW at 0x42 → `misaligned`=1 for 1 cycle, `stall`=0, `Read_Data`=0.
  - SD at 0x44 → `misaligned`=1, memory unchanged.
  - With DEPTH_WORDS=64, SD 0x1234 at 0x200, then LD 0x0 → 0x1234.
- Simultaneous and back-to-back:
  - MemRead and MemWrite both high with SD 0x55 at 0x50 → store committed, `Read_Data`=0.
  - SD immediately followed by LD at the same address → LD returns 0x55 with no extra bubble.
